// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory responder.
// Compile with DMEM_MISALIGN_CHECK_EN to reject non-word-aligned addresses.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

    // First byte address past the end of the RAM.
    function automatic longint addr_limit(input int depth);
        return longint'(depth) * 4;
    endfunction

    // The wait counter holds LATENCY-1, so it needs clog2(LATENCY) bits (minimum 1).
    function automatic int cnt_width(input int latency);
        return (latency < 2) ? 1 : $clog2(latency);
    endfunction

    localparam int     DEPTH_DEFAULT      = 256;
    localparam int     IDX_W_DEFAULT      = idx_width(DEPTH_DEFAULT);
    localparam longint ADDR_LIMIT_DEFAULT = addr_limit(DEPTH_DEFAULT);

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, combinational read captured by the responder.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY cycles to a one-cycle done pulse.
// Optional DMEM_MISALIGN_CHECK_EN turns addr[1:0] != 0 into an error response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                IDX_W      = idx_width(DEPTH);
    localparam int                CNT_W      = cnt_width(LATENCY);
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(addr_limit(DEPTH));

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               req;
    logic               req_err;
    logic               misalign;
    logic [IDX_W-1:0]   req_idx;
    logic               fire;
    logic               is_wr;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;

    assign req     = mem_read | mem_write;
    assign req_idx = addr[IDX_W+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = (addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign req_err = (mem_read & mem_write) | ({1'b0, addr} >= ADDR_LIMIT) | misalign;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        fire      = 1'b0;
        is_wr     = wr_q;
        mem_idx   = idx_q;
        mem_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = req_idx;
                    wdata_d = wdata;
                    wr_d    = mem_write;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    if (req_err) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else if (LATENCY == 1) begin
                        // No wait states: the access happens on the accepting edge itself.
                        state_d   = RESP;
                        fire      = 1'b1;
                        is_wr     = mem_write;
                        mem_idx   = req_idx;
                        mem_wdata = wdata;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    fire    = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fire && !is_wr) begin
            rdata_d = mem_rdata;
        end
    end

    assign busy_d = (state_d == WAIT);
    assign done_d = (state_d == RESP);
    // A reset on the edge that would complete a store must suppress the write.
    assign mem_we = fire & is_wr & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (mem_idx),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a LATENCY=2 and a LATENCY=1 responder driven with identical requests.
// Build with DMEM_MISALIGN_CHECK_EN to expect misaligned accesses to be rejected.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e_err;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic        MIS_ERR = 1'b1;
    localparam logic [31:0] MIS_RD  = 32'hA5A5A5A5;
`else
    localparam logic        MIS_ERR = 1'b0;
    localparam logic [31:0] MIS_RD  = 32'h44444444;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request for one edge, then drive a conflicting store while the
    // responders are busy/responding, and observe four cycles of outputs.
    task automatic run_txn(input int id, input vec_t v, input logic [31:0] exp_rd_b);
        int dc_a = -1, dc_b = -1, nd_a = 0, nd_b = 0, nb_a = 0, nb_b = 0;
        logic e_a = 1'b0, e_b = 1'b0;
        @(negedge clk);
        mem_read = v.rd; mem_write = v.wr; addr = v.a; wdata = v.wd;
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b1; wdata = 32'hBAD0BAD0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (done_a) begin nd_a++; if (dc_a < 0) begin dc_a = c; e_a = err_a; end end
            if (done_b) begin nd_b++; if (dc_b < 0) begin dc_b = c; e_b = err_b; end end
            if (busy_a) nb_a++;
            if (busy_b) nb_b++;
            if (c == 1) begin
                @(posedge clk);
                #1;
                mem_write = 1'b0;
            end
        end
        check($sformatf("t%0d_a_done_count", id), 32'(nd_a), 32'd1);
        check($sformatf("t%0d_b_done_count", id), 32'(nd_b), 32'd1);
        check($sformatf("t%0d_a_latency", id), 32'(dc_a), v.e_err ? 32'd1 : 32'd2);
        check($sformatf("t%0d_b_latency", id), 32'(dc_b), 32'd1);
        check($sformatf("t%0d_a_busy_cycles", id), 32'(nb_a), v.e_err ? 32'd0 : 32'd1);
        check($sformatf("t%0d_b_busy_cycles", id), 32'(nb_b), 32'd0);
        check($sformatf("t%0d_a_err", id), 32'(e_a), 32'(v.e_err));
        check($sformatf("t%0d_b_err", id), 32'(e_b), 32'(v.e_err));
        check($sformatf("t%0d_a_rdata", id), rdata_a, v.e_rd);
        check($sformatf("t%0d_b_rdata", id), rdata_b, exp_rd_b);
        $display("txn %0d rd=%b wr=%b addr=%h wdata=%h err_a=%b err_b=%b rdata_a=%h rdata_b=%h",
                 id, v.rd, v.wr, v.a, v.wd, e_a, e_b, rdata_a, rdata_b);
    endtask

    initial begin
        vec_t v;
        int nd;
        //                rd    wr    addr          wdata         err      rdata after
        vecs.push_back('{1'b0, 1'b1, 32'h00000010, 32'hDEADBEEF, 1'b0,   32'h00000000});
        vecs.push_back('{1'b1, 1'b0, 32'h00000010, 32'h00000000, 1'b0,   32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b1, 32'h00000000, 32'h00C0FFEE, 1'b0,   32'hDEADBEEF});
        vecs.push_back('{1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0,   32'h00C0FFEE});
        vecs.push_back('{1'b0, 1'b1, 32'h00000020, 32'h11112222, 1'b0,   32'h00C0FFEE});
        vecs.push_back('{1'b1, 1'b1, 32'h00000020, 32'h99999999, 1'b1,   32'h00C0FFEE});
        vecs.push_back('{1'b1, 1'b0, 32'h00000020, 32'h00000000, 1'b0,   32'h11112222});
        vecs.push_back('{1'b0, 1'b1, 32'h00000400, 32'h55555555, 1'b1,   32'h11112222});
        vecs.push_back('{1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0,   32'h00C0FFEE});
        vecs.push_back('{1'b0, 1'b1, 32'h000003FC, 32'hA5A5A5A5, 1'b0,   32'h00C0FFEE});
        vecs.push_back('{1'b1, 1'b0, 32'h000003FC, 32'h00000000, 1'b0,   32'hA5A5A5A5});
        vecs.push_back('{1'b0, 1'b1, 32'h00000004, 32'h44444444, 1'b0,   32'hA5A5A5A5});
        vecs.push_back('{1'b1, 1'b0, 32'h00000006, 32'h00000000, MIS_ERR, MIS_RD});
        vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFFC, 32'h00000000, 1'b1,   MIS_RD});
        vecs.push_back('{1'b0, 1'b1, 32'h00000008, 32'h0BADF00D, 1'b0,   MIS_RD});

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy_a", 32'(busy_a), 32'd0);
        check("reset_done_a", 32'(done_a), 32'd0);
        check("reset_err_a", 32'(err_a), 32'd0);
        check("reset_rdata_a", rdata_a, 32'd0);
        check("reset_busy_b", 32'(busy_b), 32'd0);
        check("reset_done_b", 32'(done_b), 32'd0);
        check("reset_rdata_b", rdata_b, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(i, vecs[i], vecs[i].e_rd);
        end

        // Reset while the LATENCY=2 responder waits on a store to 0x8; the
        // LATENCY=1 responder has already completed that store on the accepting edge.
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b1; addr = 32'h8; wdata = 32'h12345678;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(negedge clk);
        check("rstmid_a_busy_before", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done_a) nd++;
            check($sformatf("rstmid_a_busy_c%0d", c), 32'(busy_a), 32'd0);
        end
        check("rstmid_a_done_count", 32'(nd), 32'd0);
        check("rstmid_a_rdata", rdata_a, 32'd0);
        check("rstmid_b_rdata", rdata_b, 32'd0);
        $display("txn rst_mid sw addr=00000008 wdata=12345678 busy_a=%b rdata_a=%h", busy_a, rdata_a);

        v = '{1'b1, 1'b0, 32'h00000008, 32'h00000000, 1'b0, 32'h0BADF00D};
        run_txn(100, v, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
